cpu_dmem_master: RTL and testbench

CPU_DMEM_MASTER -- requirements
Module: cpu_dmem_master

---
 rtl/cpu_dmem_master_if.sv | 24 ++
 rtl/cpu_dmem_master.sv | 139 +++++++++++++
 tb/tb_cpu_dmem_master.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_dmem_master_if.sv
// cpu_dmem_master_if: write-stage request/response channel plus the Wishbone data bus.
// Signal suffixes (_i/_o) are seen from the cpu_dmem_master side.
interface cpu_dmem_master_if;
    logic        req_valid_i, req_ready_o, req_we_i, req_signed_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_data_i;
    logic        rsp_valid_o, rsp_err_o;
    logic [31:0] rsp_data_o;
    logic [31:0] wb_D_adr_o, wb_D_dat_o, wb_D_dat_i;
    logic [3:0]  wb_D_sel_o;
    logic        wb_D_we_o, wb_D_cyc_o, wb_D_stb_o, wb_D_ack_i, wb_D_err_i;
    modport master (
        input  req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_data_i,
        input  wb_D_dat_i, wb_D_ack_i, wb_D_err_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o
    );
    modport slave (
        output req_valid_i, req_we_i, req_size_i, req_signed_i, req_addr_i, req_data_i,
        output wb_D_dat_i, wb_D_ack_i, wb_D_err_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  wb_D_adr_o, wb_D_dat_o, wb_D_sel_o, wb_D_we_o, wb_D_cyc_o, wb_D_stb_o
    );
endinterface

// File: rtl/cpu_dmem_master.sv
// cpu_dmem_master: single-outstanding load/store unit driving a classic Wishbone data bus
// with big-endian byte lanes, load extension and a bounded ack wait.
module cpu_dmem_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk_i,
    input logic               rst_i,
    cpu_dmem_master_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    state_e      state_q, state_d;
    logic        ready_q, ready_d, pend_q, pend_d, cyc_q, cyc_d, we_q, we_d, sgn_q, sgn_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [1:0]  size_q, size_d, off_q, off_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, rsp_data_q, rsp_data_d, load_val;
    logic [15:0] cnt_q, cnt_d, half_sh;
    logic [7:0]  byte_sh;
    logic        accept, bad, timeout, term;
    assign accept  = bus.req_valid_i && ready_q;
    assign bad     = (bus.req_size_i == 2'b11) || (bus.req_size_i == 2'b01 && bus.req_addr_i[0]) ||
                     (bus.req_size_i == 2'b10 && bus.req_addr_i[1:0] != 2'b00);
    assign timeout = (cnt_q + 16'd1) == 16'(TIMEOUT);
    assign term    = bus.wb_D_ack_i || bus.wb_D_err_i || timeout;
    // Lane 00 lives in bits 31:24, so the shift distance is the inverted offset.
    assign byte_sh  = 8'(bus.wb_D_dat_i >> {~off_q, 3'b000});
    assign half_sh  = 16'(bus.wb_D_dat_i >> {~off_q[1], 4'b0000});
    assign load_val = size_q == 2'b00 ? {{24{sgn_q & byte_sh[7]}}, byte_sh} :
                      size_q == 2'b01 ? {{16{sgn_q & half_sh[15]}}, half_sh} : bus.wb_D_dat_i;
    always_comb begin
        state_d     = state_q;
        ready_d     = ready_q;
        pend_d      = pend_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sgn_d       = sgn_q;
        size_d      = size_q;
        off_d       = off_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        if (state_q == IDLE) begin
            ready_d = 1'b1;
            // A rejected request waits one cycle so errors keep the zero-wait response cadence.
            if (pend_q) begin
                state_d     = RESP;
                ready_d     = 1'b0;
                pend_d      = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                rsp_data_d  = '0;
            end else if (accept) begin
                ready_d = 1'b0;
                size_d  = bus.req_size_i;
                sgn_d   = bus.req_signed_i;
                off_d   = bus.req_addr_i[1:0];
                if (bad) begin
                    pend_d = 1'b1;
                end else begin
                    state_d = BUS;
                    cyc_d   = 1'b1;
                    we_d    = bus.req_we_i;
                    cnt_d   = '0;
                    adr_d   = {bus.req_addr_i[31:2], 2'b00};
                    sel_d   = bus.req_size_i == 2'b00 ? 4'b1000 >> bus.req_addr_i[1:0] :
                              bus.req_size_i == 2'b01 ? (bus.req_addr_i[1] ? 4'b0011 : 4'b1100) : 4'b1111;
                    dat_d   = bus.req_size_i == 2'b00 ? {4{bus.req_data_i[7:0]}} :
                              bus.req_size_i == 2'b01 ? {2{bus.req_data_i[15:0]}} : bus.req_data_i;
                end
            end
        end else if (state_q == BUS) begin
            cnt_d = cnt_q + 16'd1;
            if (term) begin
                state_d     = RESP;
                cyc_d       = 1'b0;
                we_d        = 1'b0;
                sel_d       = '0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = bus.wb_D_err_i || !bus.wb_D_ack_i;
                rsp_data_d  = (rsp_err_d || we_q) ? '0 : load_val;
            end
        end else begin
            state_d     = IDLE;
            ready_d     = 1'b1;
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_data_d  = '0;
        end
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            pend_q      <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            pend_q      <= pend_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sgn_q       <= sgn_d;
            size_q      <= size_d;
            off_q       <= off_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
    assign bus.req_ready_o = ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.wb_D_adr_o  = adr_q;
    assign bus.wb_D_dat_o  = dat_q;
    assign bus.wb_D_sel_o  = sel_q;
    assign bus.wb_D_we_o   = we_q;
    assign bus.wb_D_cyc_o  = cyc_q;
    assign bus.wb_D_stb_o  = cyc_q;
endmodule

// File: tb/tb_cpu_dmem_master.sv
// tb_cpu_dmem_master: directed and randomized transactions against a spec-level model
// of lane selection, extension, error and response timing.
module tb_cpu_dmem_master;
    localparam int TO = 4;
    localparam int M_ACK = 0, M_ERR = 1, M_BOTH = 2, M_TO = 3;
    logic clk = 1'b0, rst_n = 1'b0;
    int vectors = 0, miscompares = 0;
    cpu_dmem_master_if bus();
    cpu_dmem_master #(.TIMEOUT(TO)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int          o_lat, o_nstb, e_lat, e_nstb;
    logic [3:0]  o_sel, e_sel;
    logic [31:0] o_adr, o_dat, o_rdat, e_dat, e_rdat;
    logic        o_we, o_ok, o_err, o_rdy_after, o_acc, e_err, e_bad;
    // Presents one request at a negedge, plays the slave, and records what the bus and response did.
    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, d, rd, input int w, mode);
        o_acc = bus.req_ready_o;
        bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = sz; bus.req_signed_i = sg;
        bus.req_addr_i = a; bus.req_data_i = d;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0; bus.req_addr_i = $urandom; bus.req_data_i = $urandom;
        bus.req_size_i = 2'($urandom); bus.req_signed_i = 1'($urandom); bus.req_we_i = 1'($urandom);
        o_lat = -1; o_nstb = 0; o_ok = 1'b1; o_sel = '0; o_adr = '0; o_dat = '0; o_we = 1'b0;
        o_rdat = '0; o_err = 1'b0; o_rdy_after = 1'b0;
        for (int k = 1; k <= 40 && o_lat < 0; k++) begin
            if (bus.wb_D_cyc_o !== bus.wb_D_stb_o) o_ok = 1'b0;
            if (bus.wb_D_stb_o === 1'b1) begin
                if (o_nstb == 0) begin
                    o_sel = bus.wb_D_sel_o; o_adr = bus.wb_D_adr_o; o_dat = bus.wb_D_dat_o; o_we = bus.wb_D_we_o;
                end else if ({o_sel, o_adr, o_dat, o_we} !== {bus.wb_D_sel_o, bus.wb_D_adr_o, bus.wb_D_dat_o, bus.wb_D_we_o}) begin
                    o_ok = 1'b0;
                end
                bus.wb_D_ack_i = (mode == M_ACK || mode == M_BOTH) && o_nstb == w;
                bus.wb_D_err_i = (mode == M_ERR || mode == M_BOTH) && o_nstb == w;
                bus.wb_D_dat_i = bus.wb_D_ack_i ? rd : ~rd;
                o_nstb++;
            end else begin
                if (bus.wb_D_we_o !== 1'b0 || bus.wb_D_sel_o !== 4'b0000) o_ok = 1'b0;
                bus.wb_D_ack_i = 1'b0; bus.wb_D_err_i = 1'b0; bus.wb_D_dat_i = ~rd;
            end
            if (bus.rsp_valid_o === 1'b1) begin
                o_lat = k; o_rdat = bus.rsp_data_o; o_err = bus.rsp_err_o;
            end else begin
                @(negedge clk);
            end
        end
        if (o_lat >= 0) begin
            @(negedge clk);
            o_rdy_after = bus.req_ready_o && !bus.rsp_valid_o;
        end
    endtask
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, d, rd, input int w, mode);
        int off;
        logic [31:0] v;
        off = int'(a % 4);
        e_bad = sz == 3 || (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0);
        e_sel = sz == 0 ? 4'(1 << (3 - off)) : sz == 1 ? (off == 0 ? 4'hC : 4'h3) : 4'hF;
        e_dat = sz == 0 ? 32'(d[7:0]) * 32'h01010101 : sz == 1 ? 32'(d[15:0]) * 32'h00010001 : d;
        if (sz == 0) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (sg && v[7]) v = v | 32'hFFFFFF00;
        end else if (sz == 1) begin
            v = (off == 0 ? rd >> 16 : rd) & 32'hFFFF;
            if (sg && v[15]) v = v | 32'hFFFF0000;
        end else begin
            v = rd;
        end
        e_err  = e_bad || mode != M_ACK;
        e_rdat = (e_err || we) ? 32'h0 : v;
        e_lat  = e_bad ? 2 : mode == M_TO ? TO + 1 : w + 2;
        e_nstb = e_bad ? 0 : mode == M_TO ? TO : w + 1;
    endtask
    task automatic test_reset;
        #3;
        vectors++; if ({bus.req_ready_o, bus.wb_D_cyc_o, bus.wb_D_stb_o, bus.wb_D_we_o, bus.rsp_valid_o, bus.rsp_err_o} !== 6'b0) begin
            miscompares++; $display("FAIL reset_ctrl: got %b want 000000", {bus.req_ready_o, bus.wb_D_cyc_o, bus.wb_D_stb_o, bus.wb_D_we_o, bus.rsp_valid_o, bus.rsp_err_o}); end
        vectors++; if ({bus.wb_D_sel_o, bus.wb_D_adr_o, bus.wb_D_dat_o, bus.rsp_data_o} !== 100'b0) begin
            miscompares++; $display("FAIL reset_data: sel %h adr %h dat %h rsp %h want all 0", bus.wb_D_sel_o, bus.wb_D_adr_o, bus.wb_D_dat_o, bus.rsp_data_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.req_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_ready_release: got %b want 0", bus.req_ready_o); end
        @(negedge clk);
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b want 1", bus.req_ready_o); end
    endtask
    task automatic test_load_word;
        xact(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, M_ACK);
        vectors++; if (o_acc !== 1'b1) begin miscompares++; $display("FAIL ldw_ready: got %b want 1", o_acc); end
        vectors++; if (o_sel !== 4'hF) begin miscompares++; $display("FAIL ldw_sel: got %h want f", o_sel); end
        vectors++; if (o_adr !== 32'h100) begin miscompares++; $display("FAIL ldw_adr: got %h want 00000100", o_adr); end
        vectors++; if (o_we !== 1'b0) begin miscompares++; $display("FAIL ldw_we: got %b want 0", o_we); end
        vectors++; if (o_nstb !== 4) begin miscompares++; $display("FAIL ldw_stb_cycles: got %0d want 4", o_nstb); end
        vectors++; if (o_lat !== 5) begin miscompares++; $display("FAIL ldw_latency: got %0d want 5", o_lat); end
        vectors++; if ({o_err, o_rdat} !== {1'b0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL ldw_rsp: got err %b data %h want 0 deadbeef", o_err, o_rdat); end
        vectors++; if ({o_ok, o_rdy_after} !== 2'b11) begin miscompares++; $display("FAIL ldw_bus_hold: got ok %b ready %b want 1 1", o_ok, o_rdy_after); end
    endtask
    task automatic test_load_byte;
        xact(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h000000F0, 0, M_ACK);
        vectors++; if (o_sel !== 4'b0001) begin miscompares++; $display("FAIL ldb_sel: got %b want 0001", o_sel); end
        vectors++; if (o_lat !== 2) begin miscompares++; $display("FAIL ldb_latency: got %0d want 2", o_lat); end
        vectors++; if (o_rdat !== 32'hFFFFFFF0) begin miscompares++; $display("FAIL ldb_signed: got %h want fffffff0", o_rdat); end
        xact(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h000000F0, 1, M_ACK);
        vectors++; if (o_rdat !== 32'h000000F0) begin miscompares++; $display("FAIL ldb_unsigned: got %h want 000000f0", o_rdat); end
        xact(1'b0, 2'b01, 1'b1, 32'h200, 32'h0, 32'h8001_7FFF, 0, M_ACK);
        vectors++; if ({o_sel, o_rdat} !== {4'b1100, 32'hFFFF8001}) begin miscompares++; $display("FAIL ldh_signed: got sel %b data %h want 1100 ffff8001", o_sel, o_rdat); end
    endtask
    task automatic test_store_half;
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 32'h5555AAAA, 1, M_ACK);
        vectors++; if (o_sel !== 4'b0011) begin miscompares++; $display("FAIL sth_sel: got %b want 0011", o_sel); end
        vectors++; if (o_dat !== 32'hABCDABCD) begin miscompares++; $display("FAIL sth_dat: got %h want abcdabcd", o_dat); end
        vectors++; if ({o_we, o_adr} !== {1'b1, 32'h10}) begin miscompares++; $display("FAIL sth_we_adr: got %b %h want 1 00000010", o_we, o_adr); end
        vectors++; if ({o_err, o_rdat} !== 33'h0) begin miscompares++; $display("FAIL sth_rsp: got err %b data %h want 0 0", o_err, o_rdat); end
    endtask
    task automatic test_misaligned;
        logic [1:0]  szs [3] = '{2'b10, 2'b11, 2'b01};
        logic [31:0] adrs[3] = '{32'h101, 32'h0, 32'h33};
        for (int i = 0; i < 3; i++) begin
            xact(1'b0, szs[i], 1'b0, adrs[i], 32'h0, 32'h12345678, 0, M_ACK);
            vectors++; if (o_nstb !== 0) begin miscompares++; $display("FAIL misalign[%0d]_no_cyc: got %0d stb cycles want 0", i, o_nstb); end
            vectors++; if (o_lat !== 2) begin miscompares++; $display("FAIL misalign[%0d]_latency: got %0d want 2", i, o_lat); end
            vectors++; if ({o_err, o_rdat, o_rdy_after} !== {1'b1, 32'h0, 1'b1}) begin miscompares++; $display("FAIL misalign[%0d]_rsp: got err %b data %h ready %b want 1 0 1", i, o_err, o_rdat, o_rdy_after); end
        end
    endtask
    task automatic test_timeout;
        xact(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, 32'h11111111, 0, M_TO);
        vectors++; if (o_nstb !== TO) begin miscompares++; $display("FAIL to_stb_cycles: got %0d want %0d", o_nstb, TO); end
        vectors++; if ({o_err, o_rdat} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL to_rsp: got err %b data %h want 1 0", o_err, o_rdat); end
        vectors++; if (o_lat !== TO + 1) begin miscompares++; $display("FAIL to_latency: got %0d want %0d", o_lat, TO + 1); end
        xact(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 32'h22222222, 2, M_BOTH);
        vectors++; if ({o_err, o_rdat} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL ack_err_rsp: got err %b data %h want 1 0", o_err, o_rdat); end
        vectors++; if (o_lat !== 4) begin miscompares++; $display("FAIL ack_err_latency: got %0d want 4", o_lat); end
    endtask
    task automatic test_back_to_back;
        logic we, sg;
        logic [1:0] sz;
        logic [31:0] a, d, rd;
        int w, mode;
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom_range(0, 3));
            a = $urandom; d = $urandom; rd = $urandom; w = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 32'd1);
            mode = $urandom_range(0, 9) < 6 ? M_ACK : $urandom_range(1, 3);
            model(we, sz, sg, a, d, rd, w, mode);
            xact(we, sz, sg, a, d, rd, w, mode);
            vectors++; if (o_acc !== 1'b1) begin miscompares++; $display("FAIL rand[%0d]_ready: got %b want 1", i, o_acc); end
            vectors++; if (o_lat !== e_lat) begin miscompares++; $display("FAIL rand[%0d]_latency: got %0d want %0d", i, o_lat, e_lat); end
            vectors++; if (o_nstb !== e_nstb) begin miscompares++; $display("FAIL rand[%0d]_stb_cycles: got %0d want %0d", i, o_nstb, e_nstb); end
            vectors++; if ({o_err, o_rdat} !== {e_err, e_rdat}) begin miscompares++; $display("FAIL rand[%0d]_rsp: got err %b data %h want %b %h", i, o_err, o_rdat, e_err, e_rdat); end
            vectors++; if ({o_ok, o_rdy_after} !== 2'b11) begin miscompares++; $display("FAIL rand[%0d]_bus_hold: got ok %b ready %b want 1 1", i, o_ok, o_rdy_after); end
            if (!e_bad) begin
                vectors++; if ({o_sel, o_adr, o_we} !== {e_sel, a & ~32'd3, we}) begin miscompares++; $display("FAIL rand[%0d]_bus: got sel %b adr %h we %b want %b %h %b", i, o_sel, o_adr, o_we, e_sel, a & ~32'd3, we); end
                if (we) begin
                    vectors++; if (o_dat !== e_dat) begin miscompares++; $display("FAIL rand[%0d]_wdat: got %h want %h", i, o_dat, e_dat); end
                end
            end
        end
    endtask
    task automatic test_reset_mid_bus;
        logic seen;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'b10; bus.req_addr_i = 32'h40;
        bus.wb_D_ack_i = 1'b0; bus.wb_D_err_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        vectors++; if (bus.wb_D_stb_o !== 1'b1) begin miscompares++; $display("FAIL rstbus_stb_before: got %b want 1", bus.wb_D_stb_o); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if ({bus.wb_D_cyc_o, bus.wb_D_stb_o} !== 2'b00) begin miscompares++; $display("FAIL rstbus_drop: got cyc/stb %b want 00", {bus.wb_D_cyc_o, bus.wb_D_stb_o}); end
        seen = 1'b0;
        repeat (3) begin @(negedge clk); if (bus.rsp_valid_o !== 1'b0) seen = 1'b1; end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus.req_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstbus_ready: got %b want 1", bus.req_ready_o); end
        repeat (3) begin if (bus.rsp_valid_o !== 1'b0 || bus.wb_D_cyc_o !== 1'b0) seen = 1'b1; @(negedge clk); end
        vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstbus_no_rsp: got stray rsp/cyc %b want 0", seen); end
        xact(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h1234ABCD, 0, M_ACK);
        vectors++; if ({o_lat, o_err, o_rdat} !== {32'd2, 1'b0, 32'h0000ABCD}) begin miscompares++; $display("FAIL rstbus_recover: got lat %0d err %b data %h want 2 0 0000abcd", o_lat, o_err, o_rdat); end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end
    initial begin
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'b00; bus.req_signed_i = 1'b0;
        bus.req_addr_i = '0; bus.req_data_i = '0; bus.wb_D_dat_i = '0; bus.wb_D_ack_i = 1'b0; bus.wb_D_err_i = 1'b0;
        test_reset;
        test_load_word;
        test_load_byte;
        test_store_half;
        test_misaligned;
        test_timeout;
        test_back_to_back;
        test_reset_mid_bus;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
